ft2232h_tx_controller: RTL and testbench
========================================

# ft2232h_tx_controller

Transmit-side controller for the FT2232H in asynchronous 245 FIFO mode. It accepts bytes from on-chip logic over a valid/ready stream, buffers them in a small FIFO, and writes them to the FT2232H when TXE# reports space, generating WR# and driving the shared data bus. It sits beside the existing RX controller under the board top level, which owns the bidirectional `usb_d` pad and arbitrates the two controllers through `usb_d_oe`.

## Interface
- `DEPTH`, 16: transmit buffer depth in bytes, power of two, minimum 2.
- `SETUP_CYC`, 2: cycles data is driven before WR# falls, minimum 1.
- `WR_LOW_CYC`, 4: WR# low width in cycles (32 ns at 125 MHz, at least 30 ns), minimum 1.
- `HOLD_CYC`, 1: cycles data stays driven after WR# rises, minimum 1.
- `RECOVER_CYC`, 5: cycles after the hold phase during which TXE# is ignored, minimum 3.
- `COUNT_W`, 16: width of the transmitted-byte counter.

Ports:
- `clk` in 1: system clock, 125 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte from upstream logic.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: buffer can accept a byte; equals not-full.
- `usb_txen` in 1: FT2232H TXE#, active low, asynchronous to `clk`.
- `usb_wrn` out 1: FT2232H WR#, active low.
- `usb_d_out` out 8: byte driven onto the data bus.
- `usb_d_oe` out 1: top level drives `usb_d` from `usb_d_out` when this is high.
- `tx_busy` out 1: high whenever the state machine is not in IDLE.
- `tx_count` out COUNT_W: number of completed writes, wraps modulo 2^COUNT_W.

## Operation
- A push occurs when `tx_valid` and `tx_ready` are both high at a rising edge. The FIFO is show-ahead: its head byte is visible one cycle after the push.
- `usb_txen` passes through a 2-flop synchronizer; both flops reset to 1 (the "no space" value).
- State machine:
  - IDLE: if the FIFO is non-empty and the synchronized TXE# is 0, pop the FIFO, load `usb_d_out`, set `usb_d_oe`=1, and go to SETUP.
  - SETUP: lasts SETUP_CYC cycles, then drive `usb_wrn`=0 and go to STROBE.
  - STROBE: lasts WR_LOW_CYC cycles, then drive `usb_wrn`=1, increment `tx_count`, and go to HOLD.
  - HOLD: lasts HOLD_CYC cycles, then set `usb_d_oe`=0 and go to RECOVER.
  - RECOVER: lasts RECOVER_CYC cycles, then go to IDLE.
- TXE# is sampled only in IDLE. Once a write has started it always completes, even if TXE# rises part way through.
- `usb_d_out` is stable from the IDLE→SETUP edge through the end of HOLD.
- All state-machine outputs are registered, so there are no glitches on `usb_wrn`.
- A push and a pop in the same cycle are both legal. `tx_ready` is computed from the registered full flag.
- Bytes leave in exactly the order they were pushed.

## Timing
- Reset values: `usb_wrn`=1, `usb_d_oe`=0, `usb_d_out`=0x00, `tx_busy`=0, `tx_count`=0, FIFO empty, `tx_ready`=1, state IDLE.
- Reset taken mid-write: `usb_wrn` goes to 1 and `usb_d_oe` goes to 0 asynchronously, and the FIFO contents are discarded.
- Latency: a push at edge T0 into an empty FIFO, with TXE# already synchronized low, gives `usb_d_oe`=1 at T1 and `usb_wrn` falling at T1+SETUP_CYC.
- Byte period with back-to-back data: 1+SETUP_CYC+WR_LOW_CYC+HOLD_CYC+RECOVER_CYC = 13 cycles at the defaults (9.6 MB/s).
- When TXE# falls, a write can start at the earliest 2 cycles later (synchronizer delay).

## Structure
- Shared package `ft2232h_pkg` holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, RECOVER);
  - default timing constants at 125 MHz;
  - the byte width constant, shared with the RX controller.
- Sub-module `ft2232h_tx_fifo`: a show-ahead synchronous FIFO with registered full/empty flags, parameterized by DEPTH. Pointers are log2(DEPTH)+1 bits wide so full and empty are distinguishable.
- The synchronizer, timing counter, and state machine are inline in `ft2232h_tx_controller`.

## Test plan
- Single byte: TXE# low, push 0xA5 at T0 → `usb_d_oe` rises at T1; `usb_wrn` is low at T3 through T6 (4 cycles); `usb_d_out`=0xA5 while `usb_d_oe`=1; `usb_d_oe` falls at T8; `tx_count`=1.
- Fill while blocked: hold TXE# high and push 0x00..0x0F → `tx_ready`=0 after 16 accepts and no WR# activity. Then drop TXE# → 16 writes in order 0x00..0x0F with WR# falling edges exactly 13 cycles apart.
- TXE# rises during STROBE of byte 0x11 with 0x22 queued → 0x11 completes with a full 4-cycle strobe; 0x22 waits. After TXE# falls, `usb_wrn` for 0x22 falls no earlier than 2+SETUP_CYC cycles later.
- Reset asserted during STROBE with 3 bytes queued → `usb_wrn`=1 and `usb_d_oe`=0 without waiting for a clock edge. After release: `tx_count`=0, `tx_ready`=1, and no WR# pulse for 50 cycles.
- COUNT_W=4, 17 bytes sent → `tx_count` reads 1 after the last write (wrap).
- Simultaneous push and pop while full, with upstream streaming continuously → no byte lost or duplicated across 100 random bytes; the scoreboard matches the bytes captured on WR# edges.

Source files
------------

// File: rtl/ft2232h_pkg.sv
// Shared FT2232H async-245 definitions used by both the TX and RX controllers.
// Holds the byte width, the write-cycle state encoding and 125 MHz timing defaults.
package ft2232h_pkg;

  localparam int BYTE_W = 8;

  // Default write-cycle timing at 125 MHz (8 ns per cycle).
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_WR_LOW_CYC  = 4;
  localparam int DEF_HOLD_CYC    = 1;
  localparam int DEF_RECOVER_CYC = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } tx_state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft2232h_tx_controller_if.sv
// Upstream byte stream plus FT2232H transmit pins, bundled for the TX controller.
// The controller takes the slave view; upstream logic and the pad wrapper take master.
interface ft2232h_tx_controller_if;
  import ft2232h_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              usb_txen;
  logic              usb_wrn;
  logic [BYTE_W-1:0] usb_d_out;
  logic              usb_d_oe;

  modport master (
    output tx_data, tx_valid, usb_txen,
    input  tx_ready, usb_wrn, usb_d_out, usb_d_oe
  );

  modport slave (
    input  tx_data, tx_valid, usb_txen,
    output tx_ready, usb_wrn, usb_d_out, usb_d_oe
  );

endinterface

// File: rtl/ft2232h_tx_fifo.sv
// Show-ahead synchronous byte FIFO with registered full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ft2232h_tx_fifo
  import ft2232h_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [AW:0]       wr_ptr_nxt, rd_ptr_nxt;
  logic              push, pop;
  logic [BYTE_W-1:0] mem [DEPTH];

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_comb begin
    // NOTE: defaults first so every path assigns both pointers and no latch is inferred.
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (push) wr_ptr_nxt = wr_ptr + 1'b1;
    if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
  end

  // NOTE: storage is not reset; the pointers alone decide what is valid, so
  // a reset discards contents without clearing every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    end
  end

endmodule

// File: rtl/ft2232h_tx_controller.sv
// FT2232H async-245 transmit controller: buffers upstream bytes and generates
// WR# write cycles with registered, glitch-free pin outputs whenever TXE# reports space.
module ft2232h_tx_controller
  import ft2232h_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int WR_LOW_CYC  = DEF_WR_LOW_CYC,
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int RECOVER_CYC = DEF_RECOVER_CYC,
  parameter int COUNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ft2232h_tx_controller_if.slave bus,
  output logic                   tx_busy,
  output logic [COUNT_W-1:0]     tx_count
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] SETUP   = ST_SETUP;
  localparam logic [2:0] STROBE  = ST_STROBE;
  localparam logic [2:0] HOLD    = ST_HOLD;
  localparam logic [2:0] RECOVER = ST_RECOVER;

  localparam int MAX_CYC = max_of(max_of(SETUP_CYC, WR_LOW_CYC),
                                  max_of(HOLD_CYC, RECOVER_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic              txen_meta, txen_sync;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic              start;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              wrn_q, oe_q, busy_q;
  logic [BYTE_W-1:0] d_out_q;
  logic [COUNT_W-1:0] count_q;

  // TXE# is asynchronous to clk; both stages reset to "no space".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txen_meta <= 1'b1;
      txen_sync <= 1'b1;
    end else begin
      txen_meta <= bus.usb_txen;
      txen_sync <= txen_meta;
    end
  end

  ft2232h_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .wr_data (bus.tx_data),
    .wr_en   (bus.tx_valid),
    .full    (fifo_full),
    .rd_en   (start),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  // TXE# only gates the start of a write; a started write always completes.
  assign start = (state == IDLE) && !fifo_empty && !txen_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wrn_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      d_out_q <= '0;
      count_q <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        d_out_q <= fifo_head;
        oe_q    <= 1'b1;
        busy_q  <= 1'b1;
        cnt     <= CNT_W'(SETUP_CYC - 1);
        state   <= SETUP;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      // Phase timer expired: advance to the next phase of the write cycle.
      case (state)
        SETUP: begin
          wrn_q <= 1'b0;
          cnt   <= CNT_W'(WR_LOW_CYC - 1);
          state <= STROBE;
        end
        STROBE: begin
          wrn_q   <= 1'b1;
          count_q <= count_q + 1'b1;
          cnt     <= CNT_W'(HOLD_CYC - 1);
          state   <= HOLD;
        end
        HOLD: begin
          oe_q  <= 1'b0;
          cnt   <= CNT_W'(RECOVER_CYC - 1);
          state <= RECOVER;
        end
        RECOVER: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          wrn_q  <= 1'b1;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready  = !fifo_full;
  assign bus.usb_wrn   = wrn_q;
  assign bus.usb_d_oe  = oe_q;
  assign bus.usb_d_out = d_out_q;
  assign tx_busy       = busy_q;
  assign tx_count      = count_q;

endmodule

// File: tb/tb_ft2232h_tx_controller.sv
// Directed bench for ft2232h_tx_controller: a per-cycle table for the single-byte
// write, then hand-written sequences for blocking, TXE# changes, reset and wrap.
`timescale 1ns/1ps
module tb_ft2232h_tx_controller;
  import ft2232h_pkg::*;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic        reset;
  logic        busy_a, busy_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  ft2232h_tx_controller_if if_a ();
  ft2232h_tx_controller_if if_b ();

  ft2232h_tx_controller #(
    .DEPTH(16), .SETUP_CYC(2), .WR_LOW_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(5), .COUNT_W(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave), .tx_busy(busy_a), .tx_count(count_a)
  );

  ft2232h_tx_controller #(
    .DEPTH(16), .SETUP_CYC(2), .WR_LOW_CYC(4), .HOLD_CYC(1), .RECOVER_CYC(5), .COUNT_W(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave), .tx_busy(busy_b), .tx_count(count_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture the byte on the bus at every WR# falling edge of DUT A.
  logic [7:0] cap_data[$];
  int         cap_cyc[$];
  logic       prev_wrn = 1'b1;

  always @(negedge clk) begin
    if (prev_wrn && !if_a.usb_wrn) begin
      cap_data.push_back(if_a.usb_d_out);
      cap_cyc.push_back(cyc);
      check("oe_at_wr_fall", if_a.usb_d_oe, 1'b1);
    end
    prev_wrn = if_a.usb_wrn;
  end

  // All bench actions happen just after the falling edge, clear of the monitor.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; tx_valid is left high.
  task automatic push(input bit sel, input logic [7:0] b);
    int guard = 0;
    if (sel) begin if_b.tx_valid = 1'b1; if_b.tx_data = b; end
    else     begin if_a.tx_valid = 1'b1; if_a.tx_data = b; end
    while (!(sel ? if_b.tx_ready : if_a.tx_ready) && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) check("push_ready_timeout", sel ? if_b.tx_ready : if_a.tx_ready, 1'b1);
    tick();
  endtask

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        exp_wrn;
    logic        exp_oe;
    logic        exp_busy;
    logic [15:0] exp_count;
    logic        chk_d;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int base, g, low, t_drop;
    logic [7:0] b;
    logic [7:0] exp_q[$];

    // Row k: inputs applied before edge Tk, outputs expected just after Tk.
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd0, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0};

    reset         = 1'b0;
    if_a.tx_valid = 1'b0; if_a.tx_data = 8'h00; if_a.usb_txen = 1'b1;
    if_b.tx_valid = 1'b0; if_b.tx_data = 8'h00; if_b.usb_txen = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_wrn",     if_a.usb_wrn,   1'b1);
    check("rst_oe",      if_a.usb_d_oe,  1'b0);
    check("rst_d_out",   if_a.usb_d_out, 8'h00);
    check("rst_busy",    busy_a,         1'b0);
    check("rst_count",   count_a,        16'd0);
    check("rst_ready",   if_a.tx_ready,  1'b1);
    check("rst_count_b", count_b,        4'd0);
    check("rst_ready_b", if_b.tx_ready,  1'b1);
    reset = 1'b1;
    if_a.usb_txen = 1'b0;
    if_b.usb_txen = 1'b0;
    repeat (4) tick();

    // Single byte 0xA5, cycle by cycle
    for (int k = 0; k < 14; k++) begin
      if_a.tx_valid = vecs[k].valid;
      if_a.tx_data  = vecs[k].data;
      tick();
      check($sformatf("single_t%0d_wrn", k),   if_a.usb_wrn,  vecs[k].exp_wrn);
      check($sformatf("single_t%0d_oe", k),    if_a.usb_d_oe, vecs[k].exp_oe);
      check($sformatf("single_t%0d_busy", k),  busy_a,        vecs[k].exp_busy);
      check($sformatf("single_t%0d_count", k), count_a,       vecs[k].exp_count);
      check($sformatf("single_t%0d_ready", k), if_a.tx_ready, 1'b1);
      if (vecs[k].chk_d) check($sformatf("single_t%0d_d", k), if_a.usb_d_out, 8'hA5);
    end

    // Fill while TXE# is high, then drain in order with a 13-cycle byte period
    if_a.usb_txen = 1'b1;
    repeat (3) tick();
    base = cap_data.size();
    for (int i = 0; i < 16; i++) push(1'b0, 8'(i));
    check("fill_ready_full", if_a.tx_ready, 1'b0);
    if_a.tx_data = 8'h99;
    repeat (3) tick();
    check("fill_ready_held", if_a.tx_ready, 1'b0);
    if_a.tx_valid = 1'b0;
    check("fill_no_wr", cap_data.size() - base, 0);
    check("fill_idle", busy_a, 1'b0);
    if_a.usb_txen = 1'b0;
    g = 0;
    while (cap_data.size() < base + 16 && g < 16 * 13 + 40) begin tick(); g++; end
    check("fill_writes", cap_data.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      if (base + i < cap_data.size()) begin
        check($sformatf("fill_byte%0d", i), cap_data[base+i], 8'(i));
        if (i > 0) check($sformatf("fill_period%0d", i), cap_cyc[base+i] - cap_cyc[base+i-1], 13);
      end
    end
    repeat (15) tick();
    check("fill_no_extra", cap_data.size() - base, 16);
    check("fill_count", count_a, 16'd17);
    check("fill_ready_after", if_a.tx_ready, 1'b1);

    // TXE# rises during the strobe of 0x11 while 0x22 is queued
    base = cap_data.size();
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    if_a.tx_valid = 1'b0;
    g = 0;
    while (if_a.usb_wrn && g < 40) begin tick(); g++; end
    check("strobe_started", if_a.usb_wrn, 1'b0);
    if_a.usb_txen = 1'b1;
    low = 0;
    g   = 0;
    while (!if_a.usb_wrn && g < 20) begin low++; tick(); g++; end
    check("strobe_width", low, 4);
    repeat (30) tick();
    check("strobe_one_write", cap_data.size() - base, 1);
    if (cap_data.size() > base) check("strobe_byte", cap_data[base], 8'h11);
    check("strobe_waiting_idle", busy_a, 1'b0);
    if_a.usb_txen = 1'b0;
    t_drop = cyc;
    g = 0;
    while (cap_data.size() < base + 2 && g < 40) begin tick(); g++; end
    check("txe_resume_write", cap_data.size() - base, 2);
    if (cap_data.size() > base + 1) begin
      check("txe_resume_byte", cap_data[base+1], 8'h22);
      check("txe_to_wr_min_latency", (cap_cyc[base+1] - t_drop) >= 4, 1'b1);
    end
    repeat (15) tick();
    check("strobe_count", count_a, 16'd19);

    // Continuous random stream, push and pop overlap while full
    base = cap_data.size();
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      push(1'b0, b);
    end
    if_a.tx_valid = 1'b0;
    g = 0;
    while (cap_data.size() < base + 100 && g < 100 * 13 + 100) begin tick(); g++; end
    check("stream_writes", cap_data.size() - base, 100);
    for (int i = 0; i < 100; i++) begin
      if (base + i < cap_data.size()) check($sformatf("stream_byte%0d", i), cap_data[base+i], exp_q[i]);
    end
    repeat (15) tick();
    check("stream_no_extra", cap_data.size() - base, 100);
    check("stream_count", count_a, 16'd119);

    // Reset in the middle of a strobe with three bytes queued
    for (int i = 0; i < 4; i++) push(1'b0, 8'h31 + 8'(i));
    if_a.tx_valid = 1'b0;
    g = 0;
    while (if_a.usb_wrn && g < 40) begin tick(); g++; end
    check("rst_mid_in_strobe", if_a.usb_wrn, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_mid_wrn_async", if_a.usb_wrn,  1'b1);
    check("rst_mid_oe_async",  if_a.usb_d_oe, 1'b0);
    tick();
    reset = 1'b1;
    check("rst_mid_count", count_a,       16'd0);
    check("rst_mid_ready", if_a.tx_ready, 1'b1);
    check("rst_mid_busy",  busy_a,        1'b0);
    base = cap_data.size();
    repeat (50) tick();
    check("rst_mid_no_wr", cap_data.size() - base, 0);
    check("rst_mid_idle",  busy_a, 1'b0);

    // 4-bit counter wraps after 17 writes
    for (int i = 0; i < 17; i++) push(1'b1, 8'hC0 + 8'(i));
    if_b.tx_valid = 1'b0;
    repeat (17 * 13 + 30) tick();
    check("wrap_count", count_b, 4'd1);
    check("wrap_idle",  busy_b,  1'b0);
    check("wrap_ready", if_b.tx_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
